// File: rtl/mem_io_if.sv
// Byte-wide RAM bus between the CPU memory controller (master) and the responder (slave),
// plus the console TX/RX byte streams and the sticky status outputs.
interface mem_io_if;
    // Bus: one transaction every cycle, no strobe, no stall; ram_r_data answers one edge later.
    // Streams: a byte moves on a rising edge exactly when valid && ready are both high;
    // valid never waits on ready, and ready reflects only the receiver's own space.
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [7:0]  ram_w_data;
    logic [7:0]  ram_r_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        halt;
    logic        tx_overflow;

    modport master (
        output ram_rw, ram_addr, ram_w_data, tx_ready, rx_valid, rx_data,
        input  ram_r_data, tx_valid, tx_data, rx_ready, halt, tx_overflow
    );

    modport slave (
        input  ram_rw, ram_addr, ram_w_data, tx_ready, rx_valid, rx_data,
        output ram_r_data, tx_valid, tx_data, rx_ready, halt, tx_overflow
    );
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: synchronous read-first byte RAM plus an IO window
// holding the console TX/RX FIFOs, a status register and a sticky halt register.
module mem_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_LOG = 4,
    parameter int RX_DEPTH_LOG = 4
) (
    input  logic     clock,
    input  logic     reset,
    mem_io_if.slave  bus
);
    localparam logic [TX_DEPTH_LOG:0] TX_DEPTH = (TX_DEPTH_LOG + 1)'(1 << TX_DEPTH_LOG);
    localparam logic [RX_DEPTH_LOG:0] RX_DEPTH = (RX_DEPTH_LOG + 1)'(1 << RX_DEPTH_LOG);

    logic [7:0] mem    [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] tx_mem [0:(1 << TX_DEPTH_LOG) - 1];
    logic [7:0] rx_mem [0:(1 << RX_DEPTH_LOG) - 1];

    logic [TX_DEPTH_LOG-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_DEPTH_LOG:0]   tx_cnt_q, tx_cnt_d;
    logic [RX_DEPTH_LOG-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_DEPTH_LOG:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]              r_data_q, r_data_d;
    logic                    halt_q, halt_d;
    logic                    ovf_q, ovf_d;

    logic                  is_ram, is_io, io_wr0, io_rd0, io_wr4, io_rd4;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push, tx_pop, rx_push, rx_pop, mem_we;

    always_comb begin
        is_ram = (bus.ram_addr[31:17] == '0);
        is_io  = (bus.ram_addr[31:16] == 16'h0003);
        idx    = bus.ram_addr[ADDR_WIDTH-1:0];
        io_wr0 = is_io &&  bus.ram_rw && (bus.ram_addr[2:0] == 3'd0);
        io_rd0 = is_io && !bus.ram_rw && (bus.ram_addr[2:0] == 3'd0);
        io_wr4 = is_io &&  bus.ram_rw && (bus.ram_addr[2:0] == 3'd4);
        io_rd4 = is_io && !bus.ram_rw && (bus.ram_addr[2:0] == 3'd4);

        tx_full  = (tx_cnt_q == TX_DEPTH);
        tx_empty = (tx_cnt_q == '0);
        rx_full  = (rx_cnt_q == RX_DEPTH);
        rx_empty = (rx_cnt_q == '0);

        // Full/empty are sampled at cycle start, so a simultaneous pop never opens room for a push.
        tx_push = io_wr0 && !halt_q && !tx_full && !reset;
        tx_pop  = bus.tx_ready && !tx_empty;
        rx_push = bus.rx_valid && !rx_full && !reset;
        rx_pop  = io_rd0 && !rx_empty;
        mem_we  = is_ram && bus.ram_rw && !halt_q && !reset;
    end

    always_comb begin
        r_data_d  = 8'h00;
        halt_d    = halt_q || io_wr4;
        ovf_d     = ovf_q || (io_wr0 && !halt_q && tx_full);
        tx_wptr_d = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
        rx_wptr_d = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;

        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // RAM returns the pre-write byte on write cycles; IO writes always return zero.
        if (is_ram) begin
            r_data_d = mem[idx];
        end else if (rx_pop) begin
            r_data_d = rx_mem[rx_rptr_q];
        end else if (io_rd4) begin
            r_data_d = {6'b0, !rx_empty, tx_full};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            r_data_q  <= 8'h00;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            r_data_q  <= r_data_d;
            halt_q    <= halt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage arrays carry no reset: RAM contents survive reset, stale FIFO slots are unreachable.
    always_ff @(posedge clock) begin
        if (mem_we)  mem[idx]          <= bus.ram_w_data;
        if (tx_push) tx_mem[tx_wptr_q] <= bus.ram_w_data;
        if (rx_push) rx_mem[rx_wptr_q] <= bus.rx_data;
    end

    assign bus.ram_r_data  = r_data_q;
    assign bus.tx_valid    = !tx_empty;
    assign bus.tx_data     = tx_mem[tx_rptr_q];
    assign bus.rx_ready    = !rx_full;
    assign bus.halt        = halt_q;
    assign bus.tx_overflow = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed steps from the test plan followed by a random phase,
// scored against a queue-based model of the RAM, both FIFOs and the sticky flags.
module tb_mem_io_responder;
    logic clock = 1'b0;
    logic reset;
    mem_io_if bus_if();

    mem_io_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit         known_q[$];
    logic [7:0] ref_mem[int];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_halt;
    bit         m_ovf;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One bus cycle of the reference model, evaluated against the state at cycle start.
    task automatic model_cycle(input bit rw, input logic [31:0] addr, input logic [7:0] wd,
                               input bit txr, input bit rxv, input logic [7:0] rxd);
        int tx_n = tx_q.size();
        int rx_n = rx_q.size();
        logic [7:0] e = 8'h00;
        bit kn = 1'b1;
        if (txr && tx_n > 0) void'(tx_q.pop_front());
        if (addr[31:17] == 15'd0) begin
            int idx = int'(addr[16:0]);
            if (ref_mem.exists(idx)) e = ref_mem[idx];
            else kn = 1'b0;
            if (rw && !m_halt) ref_mem[idx] = wd;
        end else if (addr[31:16] == 16'h0003) begin
            if (rw) begin
                if (addr[2:0] == 3'd0 && !m_halt) begin
                    if (tx_n < 16) tx_q.push_back(wd);
                    else m_ovf = 1'b1;
                end
                if (addr[2:0] == 3'd4) m_halt = 1'b1;
            end else begin
                if (addr[2:0] == 3'd0 && rx_n > 0) e = rx_q.pop_front();
                if (addr[2:0] == 3'd4) e = {6'b0, rx_n > 0, tx_n == 16};
            end
        end
        if (rxv && rx_n < 16) rx_q.push_back(rxd);
        exp_q.push_back(e);
        known_q.push_back(kn);
    endtask

    task automatic compare();
        logic [7:0] e = exp_q.pop_front();
        bit kn = known_q.pop_front();
        if (kn) check("ram_r_data", bus_if.ram_r_data, e);
        check("tx_valid", 8'(bus_if.tx_valid), 8'(tx_q.size() != 0));
        if (tx_q.size() != 0) check("tx_data", bus_if.tx_data, tx_q[0]);
        check("rx_ready", 8'(bus_if.rx_ready), 8'(rx_q.size() != 16));
        check("halt", 8'(bus_if.halt), 8'(m_halt));
        check("tx_overflow", 8'(bus_if.tx_overflow), 8'(m_ovf));
    endtask

    task automatic step(input bit rw, input logic [31:0] addr, input logic [7:0] wd,
                        input bit txr = 1'b0, input bit rxv = 1'b0, input logic [7:0] rxd = 8'h00);
        bus_if.ram_rw     = rw;
        bus_if.ram_addr   = addr;
        bus_if.ram_w_data = wd;
        bus_if.tx_ready   = txr;
        bus_if.rx_valid   = rxv;
        bus_if.rx_data    = rxd;
        model_cycle(rw, addr, wd, txr, rxv, rxd);
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        bus_if.ram_rw     = 1'b0;
        bus_if.ram_addr   = 32'h0002_0000;
        bus_if.ram_w_data = 8'h00;
        bus_if.tx_ready   = 1'b0;
        bus_if.rx_valid   = 1'b0;
        bus_if.rx_data    = 8'h00;
        @(posedge clock);
        #1;
        tx_q.delete();
        rx_q.delete();
        m_halt = 1'b0;
        m_ovf  = 1'b0;
        exp_q.push_back(8'h00);
        known_q.push_back(1'b1);
        compare();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Seed the low RAM window so later reads have known contents.
        for (int i = 0; i < 64; i++) step(1'b1, 32'(i), 8'($urandom));

        step(1'b1, 32'h0000_0010, 8'hA5);
        step(1'b0, 32'h0000_0010, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0000_0010 + 32'(i), 8'h00);
        step(1'b1, 32'h0004_0000, 8'h55);
        step(1'b0, 32'h0004_0000, 8'h00);
        step(1'b0, 32'h0003_0002, 8'h00);

        // TX path with consumer stalled, then released.
        step(1'b1, 32'h0003_0000, 8'h48);
        step(1'b1, 32'h0003_0000, 8'h69);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0002_0000, 8'h00, 1'b1);

        // TX overflow: seventeen pushes into sixteen slots.
        for (int i = 0; i < 17; i++) step(1'b1, 32'h0003_0000, 8'(8'h80 + i));
        step(1'b0, 32'h0003_0004, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0002_0000, 8'h00, 1'b1);

        // RX path.
        step(1'b0, 32'h0002_0000, 8'h00, 1'b0, 1'b1, 8'h31);
        step(1'b0, 32'h0002_0000, 8'h00, 1'b0, 1'b1, 8'h32);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0003_0000, 8'h00);
        step(1'b0, 32'h0003_0004, 8'h00);
        for (int i = 0; i < 17; i++) step(1'b0, 32'h0002_0000, 8'h00, 1'b0, 1'b1, 8'(8'h40 + i));
        step(1'b0, 32'h0003_0004, 8'h00);
        step(1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'hEE);
        for (int i = 0; i < 17; i++) step(1'b0, 32'h0003_0000, 8'h00);

        // TX full with drain and push in the same cycle.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 32'h0003_0000, 8'(8'hC0 + i));
        step(1'b1, 32'h0003_0000, 8'hCC, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0002_0000, 8'h00, 1'b1);

        // Reset with bytes queued in both FIFOs.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0003_0000, 8'(8'h10 + i), 1'b0, 1'b1, 8'(8'h20 + i));
        do_reset();
        step(1'b0, 32'h0003_0000, 8'h00);

        // Random traffic over RAM, both FIFOs, status and unmapped space.
        for (int i = 0; i < 400; i++) begin
            int sel = $urandom_range(0, 3);
            bit rw = 1'($urandom_range(0, 1));
            logic [31:0] a;
            case (sel)
                0:       a = 32'($urandom_range(0, 63));
                1:       a = 32'h0003_0000;
                2:       begin a = 32'h0003_0004; rw = 1'b0; end
                default: a = ($urandom_range(0, 1) != 0) ? 32'h0005_0000 : 32'h0003_0000 + 32'($urandom_range(1, 3));
            endcase
            step(rw, a, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Halt blocks RAM writes and TX pushes; reset clears it but keeps RAM.
        step(1'b1, 32'h0003_0004, 8'h00);
        step(1'b1, 32'h0000_0020, 8'h77);
        step(1'b0, 32'h0000_0020, 8'h00);
        step(1'b1, 32'h0003_0000, 8'h99);
        step(1'b0, 32'h0002_0000, 8'h00, 1'b0, 1'b1, 8'h5A);
        step(1'b0, 32'h0003_0000, 8'h00);
        do_reset();
        step(1'b0, 32'h0000_0020, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
